uart_frame_tx: RTL and testbench

- UART transmit-side framer: returns a result block (e.g. AES ciphertext) from the FPGA to the host over TX_UART.
- Complements the host-to-FPGA receive framer. That framer accepts a header byte followed by 16-byte key/plaintext payloads.
- Sends one header byte, then NUM_BYTES payload bytes, MSB byte first. Each byte is 8N1, LSB bit first.
- Sits between the AES/DRAM control core and the TX_UART pad.

---
 rtl/uart_frame_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_frame_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//   UART transmit framer. On an accepted start it latches the payload and
//   sends an optional header byte followed by NUM_BYTES payload bytes, MSB
//   byte first. Each byte is sent as 8N1, LSB bit first. There is no idle
//   gap between the bytes of a frame.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset; aborts any frame in flight
//   start  in   one-cycle request, only honoured while idle
//   data   in   payload, byte 0 = data[8*NUM_BYTES-1 -: 8], latched on start
//   tx     out  registered serial line, idle high
//   busy   out  high while a frame is on the line
//   done   out  one-cycle pulse on the cycle after the final stop bit
module uart_frame_tx #(
  parameter int         CLK_DIV     = 10416,
  parameter int         NUM_BYTES   = 16,
  parameter logic [7:0] HEADER      = 8'h01,
  parameter bit         SEND_HEADER = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] data,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int TOTAL   = NUM_BYTES + (SEND_HEADER ? 1 : 0);
  localparam int FRAME_W = 8 * TOTAL;
  localparam int BAUD_W  = $clog2(CLK_DIV);
  localparam int BYTE_W  = $clog2(NUM_BYTES + 2);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_reg, state_next;
  logic [BAUD_W-1:0]   baud_reg, baud_next;
  logic [2:0]          bit_reg, bit_next;
  logic [BYTE_W-1:0]   byte_reg, byte_next;
  logic [FRAME_W-1:0]  frame_reg, frame_next;
  logic                tx_reg, tx_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  logic [FRAME_W-1:0]  load_frame;
  logic [7:0]          cur_byte;
  logic                baud_end;

  // Assemble the whole frame once so the byte currently on the wire is
  // always the top byte of frame_reg.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_payload
      assign load_frame[8*gi +: 8] = data[8*gi +: 8];
    end
    if (SEND_HEADER) begin : g_header
      assign load_frame[FRAME_W-1 -: 8] = HEADER;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      byte_reg  <= '0;
      frame_reg <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      frame_reg <= frame_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    frame_next = frame_reg;
    done_next  = 1'b0;
    baud_end   = (baud_reg == BAUD_LAST);

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        byte_next = '0;
        if (start) begin
          frame_next = load_frame;
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          if (byte_reg == BYTE_LAST) begin
            byte_next  = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            // Next byte follows straight on: no idle cycle between bytes.
            byte_next  = byte_reg + BYTE_W'(1);
            frame_next = frame_reg << 8;
            state_next = START;
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // tx is computed from the next-state values and registered, so the pin
    // changes on the same edge as the state and never glitches.
    cur_byte = frame_next[FRAME_W-1 -: 8];
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = cur_byte[bit_next];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with CLK_DIV=16, NUM_BYTES=16.
// Main instance uses HEADER=01; a second instance uses HEADER=A5 for
// bit-level timing. Inputs are driven and outputs sampled on the falling edge.
module tb_uart_frame_tx;

  localparam int CLK_DIV = 16;
  localparam int NB      = 16;
  localparam int FRAME_CYC = 10 * CLK_DIV * (NB + 1);

  localparam logic [127:0] D1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] D2 = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         start2 = 1'b0;
  logic [127:0] data = '0;
  logic         tx, busy, done;
  logic         tx2, busy2, done2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  uart_frame_tx #(.CLK_DIV(CLK_DIV), .NUM_BYTES(NB), .HEADER(8'h01), .SEND_HEADER(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .tx(tx), .busy(busy), .done(done)
  );

  uart_frame_tx #(.CLK_DIV(CLK_DIV), .NUM_BYTES(NB), .HEADER(8'hA5), .SEND_HEADER(1'b1)) dut_a5 (
    .clk(clk), .rst(rst), .start(start2), .data(data),
    .tx(tx2), .busy(busy2), .done(done2)
  );

  // Pulse start for one cycle; returns at the falling edge of start-bit cycle 0.
  task automatic pulse_start(input logic [127:0] d);
    data  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Receiver model: samples each bit at its middle. Called in start-bit
  // cycle 0, returns in the cycle after the final stop bit. Optionally
  // pulses start with new data at frame cycle inject_at.
  task automatic rx_frame(input int inject_at, input logic [127:0] inject_data,
                          output logic [135:0] got, output int busy_n,
                          output int done_n, output int frame_err);
    logic [7:0] b;
    int c;
    got = '0; busy_n = 0; done_n = 0; frame_err = 0; c = 0;
    for (int by = 0; by < NB + 1; by++) begin
      b = '0;
      for (int bi = 0; bi < 10; bi++) begin
        for (int s = 0; s < CLK_DIV; s++) begin
          if (busy === 1'b1) busy_n++;
          if (done === 1'b1) done_n++;
          if (s == CLK_DIV / 2) begin
            if (bi == 0) begin
              if (tx !== 1'b0) frame_err++;
            end else if (bi == 9) begin
              if (tx !== 1'b1) frame_err++;
            end else begin
              b[bi-1] = tx;
            end
          end
          if (c == inject_at) begin
            start = 1'b1;
            data  = inject_data;
          end else begin
            start = 1'b0;
          end
          c++;
          @(negedge clk);
        end
      end
      got = {got[127:0], b};
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    data = D1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL reset_cycle%0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0", i, tx, busy, done);
      else pass_cnt++;
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL reset_no_frame: busy=%b tx=%b, required busy=0 tx=1", busy, tx);
    else pass_cnt++;
    $display("test_reset: done");
  endtask

  task automatic test_single_frame();
    logic [135:0] got;
    int busy_n, done_n, ferr;
    int extra_busy, extra_done;
    pulse_start(D1);
    chk_cnt++;
    if (tx !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_latency: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
    else pass_cnt++;
    rx_frame(-1, '0, got, busy_n, done_n, ferr);
    chk_cnt++;
    if (got !== {8'h01, D1})
      $display("FAIL single_payload: got %h, required %h", got, {8'h01, D1});
    else pass_cnt++;
    chk_cnt++;
    if (busy_n != FRAME_CYC || ferr != 0 || done_n != 0)
      $display("FAIL single_timing: busy_cycles=%0d framing_err=%0d early_done=%0d, required %0d/0/0",
               busy_n, ferr, done_n, FRAME_CYC);
    else pass_cnt++;
    chk_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL single_done: done=%b busy=%b tx=%b, required done=1 busy=0 tx=1", done, busy, tx);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0)
      $display("FAIL single_done_width: done=%b one cycle later, required 0", done);
    else pass_cnt++;
    extra_busy = 0; extra_done = 0;
    repeat (50) begin
      if (busy === 1'b1) extra_busy++;
      if (done === 1'b1) extra_done++;
      @(negedge clk);
    end
    chk_cnt++;
    if (extra_busy != 0 || extra_done != 0)
      $display("FAIL single_idle_after: busy_cycles=%0d done_pulses=%0d, required 0/0", extra_busy, extra_done);
    else pass_cnt++;
    $display("test_single_frame: got=%h busy_cycles=%0d", got, busy_n);
  endtask

  task automatic test_bit_timing();
    logic [9:0] exp_bits;
    int err, waited;
    exp_bits = 10'b11_0100_1010;   // index = bit slot: start, A5 LSB..MSB, stop
    data = D1;
    chk_cnt++;
    if (tx2 !== 1'b1)
      $display("FAIL timing_idle: tx=%b before start, required 1", tx2);
    else pass_cnt++;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int bi = 0; bi < 10; bi++) begin
      err = 0;
      for (int s = 0; s < CLK_DIV; s++) begin
        if (tx2 !== exp_bits[bi]) err++;
        @(negedge clk);
      end
      chk_cnt++;
      if (err != 0)
        $display("FAIL timing_bit%0d: %0d of %0d cycles wrong, required level %b throughout",
                 bi, err, CLK_DIV, exp_bits[bi]);
      else pass_cnt++;
    end
    waited = 0;
    while (done2 !== 1'b1 && waited < FRAME_CYC) begin
      @(negedge clk);
      waited++;
    end
    chk_cnt++;
    if (done2 !== 1'b1)
      $display("FAIL timing_done: no done within %0d cycles, required a done pulse", FRAME_CYC);
    else pass_cnt++;
    @(negedge clk);
    $display("test_bit_timing: header A5 checked over 10 bit slots");
  endtask

  task automatic test_ignored_start();
    logic [135:0] got;
    int busy_n, done_n, ferr;
    int extra_busy, extra_done;
    pulse_start(D1);
    rx_frame(100, D2, got, busy_n, done_n, ferr);
    chk_cnt++;
    if (got !== {8'h01, D1} || ferr != 0)
      $display("FAIL ignored_payload: got %h framing_err=%0d, required %h", got, ferr, {8'h01, D1});
    else pass_cnt++;
    chk_cnt++;
    if (done !== 1'b1 || done_n != 0 || busy_n != FRAME_CYC)
      $display("FAIL ignored_done: done=%b early_done=%0d busy_cycles=%0d, required 1/0/%0d",
               done, done_n, busy_n, FRAME_CYC);
    else pass_cnt++;
    @(negedge clk);
    extra_busy = 0; extra_done = 0;
    repeat (FRAME_CYC + 20) begin
      if (busy === 1'b1) extra_busy++;
      if (done === 1'b1) extra_done++;
      @(negedge clk);
    end
    chk_cnt++;
    if (extra_busy != 0 || extra_done != 0)
      $display("FAIL ignored_no_second: busy_cycles=%0d done_pulses=%0d, required 0/0", extra_busy, extra_done);
    else pass_cnt++;
    $display("test_ignored_start: got=%h", got);
  endtask

  task automatic test_back_to_back();
    logic [135:0] got;
    int busy_n, done_n, ferr;
    pulse_start(D1);
    rx_frame(-1, '0, got, busy_n, done_n, ferr);
    chk_cnt++;
    if (done !== 1'b1)
      $display("FAIL b2b_first_done: done=%b, required 1", done);
    else pass_cnt++;
    pulse_start(D2);   // start asserted during the done cycle
    chk_cnt++;
    if (tx !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_restart: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
    else pass_cnt++;
    rx_frame(-1, '0, got, busy_n, done_n, ferr);
    chk_cnt++;
    if (got !== {8'h01, D2} || ferr != 0 || busy_n != FRAME_CYC)
      $display("FAIL b2b_payload: got %h framing_err=%0d busy_cycles=%0d, required %h/0/%0d",
               got, ferr, busy_n, {8'h01, D2}, FRAME_CYC);
    else pass_cnt++;
    chk_cnt++;
    if (done !== 1'b1)
      $display("FAIL b2b_second_done: done=%b, required 1", done);
    else pass_cnt++;
    @(negedge clk);
    $display("test_back_to_back: got=%h", got);
  endtask

  task automatic test_mid_reset();
    logic [135:0] got;
    int busy_n, done_n, ferr;
    int bad;
    pulse_start(D2);
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midrst_abort: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0", tx, busy, done);
    else pass_cnt++;
    bad = 0;
    repeat (30) begin
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    chk_cnt++;
    if (bad != 0)
      $display("FAIL midrst_quiet: %0d cycles not idle after abort, required 0", bad);
    else pass_cnt++;
    pulse_start(D1);
    rx_frame(-1, '0, got, busy_n, done_n, ferr);
    chk_cnt++;
    if (got !== {8'h01, D1} || ferr != 0 || done !== 1'b1)
      $display("FAIL midrst_recover: got %h framing_err=%0d done=%b, required %h/0/1",
               got, ferr, done, {8'h01, D1});
    else pass_cnt++;
    @(negedge clk);
    $display("test_mid_reset: recovered frame got=%h", got);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_bit_timing();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
